// File: rtl/fifo_pop_router.sv
// Read-side controller for the FIFO bank: round-robin pops from four source FIFOs,
// two-cycle capture/route pipeline into four destination FIFOs, with almost_full hold-off.
module fifo_pop_router #(
   parameter int DATA_W = 10,
   parameter int N_SRC  = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [N_SRC-1:0]  src_empty,
   input  logic [DATA_W-1:0] src_data0,
   input  logic [DATA_W-1:0] src_data1,
   input  logic [DATA_W-1:0] src_data2,
   input  logic [DATA_W-1:0] src_data3,
   input  logic [N_SRC-1:0]  dst_almost_full,
   output logic [N_SRC-1:0]  src_pop,
   output logic [N_SRC-1:0]  dst_push,
   output logic [DATA_W-1:0] dst_data,
   output logic              idle,
   output logic              paused
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         last_q, last_d;
   logic [1:0]         sel_q, sel_d;
   logic               vld_q, vld_d;
   logic [N_SRC-1:0]   dst_push_q, dst_push_d;
   logic [DATA_W-1:0]  dst_data_q, dst_data_d;

   logic               grant_vld;
   logic [1:0]         grant_idx;
   logic [1:0]         idx;
   logic               pop_fire;
   logic [DATA_W-1:0]  cap_data;

   // Search order last+1 .. last+4; the 2-bit sum wraps so the last probe is last_q itself.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = last_q;
      idx       = '0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         idx = last_q + 2'(k);
         if (!grant_vld && !src_empty[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

   always_comb begin
      state_d = IDLE;
      if (!(&src_empty)) begin
         state_d = (|dst_almost_full) ? PAUSE : ACTIVE;
      end
   end

   always_comb begin
      pop_fire = (state_q == ACTIVE) && grant_vld;
      src_pop  = '0;
      last_d   = last_q;
      sel_d    = sel_q;
      vld_d    = pop_fire;
      if (pop_fire) begin
         src_pop = N_SRC'(1) << grant_idx;
         last_d  = grant_idx;
         sel_d   = grant_idx;
      end
   end

   always_comb begin
      case (sel_q)
         2'd0:    cap_data = src_data0;
         2'd1:    cap_data = src_data1;
         2'd2:    cap_data = src_data2;
         default: cap_data = src_data3;
      endcase
   end

   // A zero word is still popped and captured, but never pushed downstream.
   always_comb begin
      dst_data_d = dst_data_q;
      dst_push_d = '0;
      if (vld_q) begin
         dst_data_d = cap_data;
         if (cap_data != '0) begin
            dst_push_d = N_SRC'(1) << cap_data[DATA_W-1 -: 2];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= IDLE;
         last_q     <= 2'd3;
         sel_q      <= '0;
         vld_q      <= 1'b0;
         dst_push_q <= '0;
         dst_data_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         sel_q      <= sel_d;
         vld_q      <= vld_d;
         dst_push_q <= dst_push_d;
         dst_data_q <= dst_data_d;
      end
   end

   assign dst_push = dst_push_q;
   assign dst_data = dst_data_q;
   assign idle     = (state_q == IDLE) && !vld_q && !(|dst_push_q);
   assign paused   = (state_q == PAUSE);

endmodule

// File: tb/tb_fifo_pop_router.sv
// Bench for fifo_pop_router: source FIFO model, push scoreboard, vector table,
// directed corner sequences and a randomized soak.
module tb_fifo_pop_router;

   logic       clk;
   logic       reset_L;
   logic [3:0] src_empty;
   logic [9:0] sd [4];
   logic [3:0] dst_almost_full;
   logic [3:0] src_pop;
   logic [3:0] dst_push;
   logic [9:0] dst_data;
   logic       idle;
   logic       paused;

   fifo_pop_router #(.DATA_W(10), .N_SRC(4)) dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .src_empty       (src_empty),
      .src_data0       (sd[0]),
      .src_data1       (sd[1]),
      .src_data2       (sd[2]),
      .src_data3       (sd[3]),
      .dst_almost_full (dst_almost_full),
      .src_pop         (src_pop),
      .dst_push        (dst_push),
      .dst_data        (dst_data),
      .idle            (idle),
      .paused          (paused)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [9:0] q     [4][$];
   logic [9:0] exp_q [4][$];
   logic [1:0] mdl_last = 2'd3;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [3:0] rr_expect(input logic [1:0] last, input logic [3:0] empt);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (int'(last) + k) % 4;
         if (!empt[i]) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   function automatic bit qs_empty();
      for (int s = 0; s < 4; s++) if (q[s].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic load(input int s, input logic [9:0] w);
      q[s].push_back(w);
      if (w != 10'h000) exp_q[s].push_back(w);
   endtask

   task automatic sb_push(input logic [3:0] d, input logic [9:0] w);
      bit found;
      found = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (!found && exp_q[s].size() > 0 && exp_q[s][0] == w) begin
            found = 1'b1;
            void'(exp_q[s].pop_front());
         end
      end
      chk("push_expected_word", 32'(found), 32'd1);
      chk("push_dst_from_field", 32'(d), 32'(4'b0001 << w[9:8]));
   endtask

   // Entered at a falling edge; checks invariants, then advances one cycle
   // and updates the source FIFO model (registered empty, data after pop).
   task automatic cyc();
      logic [3:0] pops;
      pops = src_pop;
      chk("pop_onehot_nonempty", 32'({$onehot0(src_pop), |(src_pop & src_empty)}), 32'd2);
      chk("push_onehot", 32'($onehot0(dst_push)), 32'd1);
      if (paused) chk("no_pop_in_pause", 32'(src_pop), 32'd0);
      if (src_pop != 4'b0000) begin
         chk("rr_order", 32'(src_pop), 32'(rr_expect(mdl_last, src_empty)));
         for (int i = 0; i < 4; i++) if (src_pop[i]) mdl_last = 2'(i);
      end
      if (dst_push != 4'b0000) sb_push(dst_push, dst_data);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (pops[i] && q[i].size() > 0) sd[i] = q[i].pop_front();
         src_empty[i] = (q[i].size() == 0);
      end
      @(negedge clk);
   endtask

   task automatic wait_pop(input string nm);
      int k;
      k = 0;
      while (src_pop == 4'b0000 && k < 20) begin
         cyc();
         k++;
      end
      chk(nm, 32'(src_pop != 4'b0000), 32'd1);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (!(idle && qs_empty()) && k < 300) begin
         cyc();
         k++;
      end
      chk("drain_idle", 32'(idle), 32'd1);
      for (int s = 0; s < 4; s++) chk("no_word_lost", exp_q[s].size(), 32'd0);
   endtask

   function automatic logic [9:0] rr_word(input int s, input int j);
      return {2'((s + j) % 4), 4'(s), 4'(j + 1)};
   endfunction

   typedef struct {
      int unsigned src;
      logic [9:0]  word;
      logic [3:0]  pop;
      logic [3:0]  push;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [3:0] last_pop;
      int         lp;
      int unsigned rcnt;

      tbl[0] = '{2, 10'h1A5, 4'b0100, 4'b0010};
      tbl[1] = '{0, 10'h000, 4'b0001, 4'b0000};
      tbl[2] = '{3, 10'h3C7, 4'b1000, 4'b1000};
      tbl[3] = '{1, 10'h012, 4'b0010, 4'b0001};
      tbl[4] = '{0, 10'h2FF, 4'b0001, 4'b0100};
      tbl[5] = '{3, 10'h100, 4'b1000, 4'b0010};

      reset_L         = 1'b0;
      src_empty       = 4'b1111;
      dst_almost_full = 4'b0000;
      for (int i = 0; i < 4; i++) sd[i] = 10'h000;
      @(negedge clk);
      @(negedge clk);
      chk("rst_src_pop", 32'(src_pop), 32'd0);
      chk("rst_dst_push", 32'(dst_push), 32'd0);
      chk("rst_dst_data", 32'(dst_data), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_paused", 32'(paused), 32'd0);
      reset_L = 1'b1;
      @(negedge clk);

      // Single-word vectors: pop at t, push at t+2, idle again at t+3.
      for (int v = 0; v < 6; v++) begin
         load(int'(tbl[v].src), tbl[v].word);
         wait_pop("tbl_pop_timeout");
         chk("tbl_pop", 32'(src_pop), 32'(tbl[v].pop));
         cyc();
         chk("tbl_push_t1", 32'(dst_push), 32'd0);
         cyc();
         chk("tbl_push_t2", 32'(dst_push), 32'(tbl[v].push));
         if (tbl[v].push != 4'b0000) chk("tbl_data_t2", 32'(dst_data), 32'(tbl[v].word));
         cyc();
         chk("tbl_idle_t3", 32'(idle), 32'd1);
      end

      // Wrap and skip: last grant is 3, sources 0/1 empty.
      load(2, 10'h0AB);
      load(3, 10'h2CD);
      wait_pop("wrap_timeout");
      chk("wrap_skip_pop2", 32'(src_pop), 32'h4);
      cyc();
      chk("wrap_next_pop3", 32'(src_pop), 32'h8);
      drain();

      // Round robin: 3 words in every source.
      for (int j = 0; j < 3; j++) for (int s = 0; s < 4; s++) load(s, rr_word(s, j));
      wait_pop("rr_timeout");
      for (int k = 0; k < 14; k++) begin
         if (k < 12) chk("rr_pop_seq", 32'(src_pop), 32'(1 << (k % 4)));
         if (k >= 2) begin
            chk("rr_push_streak", 32'(dst_push != 4'b0000), 32'd1);
            chk("rr_data_seq", 32'(dst_data), 32'(rr_word((k - 2) % 4, (k - 2) / 4)));
         end
         cyc();
      end
      chk("rr_push_stops", 32'(dst_push), 32'd0);
      drain();

      // Zero word followed by a normal word from the same source.
      load(0, 10'h000);
      load(0, 10'h155);
      wait_pop("zero_timeout");
      cyc();
      chk("zero_second_pop", 32'(src_pop), 32'h1);
      cyc();
      chk("zero_discarded", 32'(dst_push), 32'd0);
      cyc();
      chk("zero_next_push", 32'(dst_push), 32'h2);
      chk("zero_next_data", 32'(dst_data), 32'h155);
      drain();

      // Backpressure: almost_full rises while a pop is in progress.
      for (int j = 0; j < 4; j++) for (int s = 0; s < 4; s++)
         load(s, {2'(j % 4), 4'(s), 4'(j + 8)});
      wait_pop("bp_timeout");
      cyc(); cyc(); cyc();
      last_pop = src_pop;
      chk("bp_pop_before", 32'(last_pop != 4'b0000), 32'd1);
      dst_almost_full = 4'b0010;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("bp_pop_held", 32'(src_pop), 32'd0);
         chk("bp_paused", 32'(paused), 32'd1);
         chk("bp_inflight_push", 32'(dst_push != 4'b0000), 32'(i < 2));
         if (i == 3) dst_almost_full = 4'b0000;
         cyc();
      end
      lp = 0;
      for (int i = 0; i < 4; i++) if (last_pop[i]) lp = i;
      chk("bp_resume_next", 32'(src_pop), 32'(1 << ((lp + 1) % 4)));
      chk("bp_unpaused", 32'(paused), 32'd0);
      drain();

      // Reset mid-stream.
      for (int j = 0; j < 3; j++) for (int s = 0; s < 4; s++)
         load(s, {2'(s), 4'(s), 4'(j + 3)});
      wait_pop("mrst_timeout");
      cyc(); cyc(); cyc();
      reset_L = 1'b0;
      #1;
      chk("mrst_pop_zero", 32'(src_pop), 32'd0);
      chk("mrst_push_zero", 32'(dst_push), 32'd0);
      for (int s = 0; s < 4; s++) begin
         q[s].delete();
         exp_q[s].delete();
         sd[s] = 10'h000;
      end
      src_empty = 4'b1111;
      mdl_last  = 2'd3;
      @(negedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("mrst_no_push_after", 32'(dst_push), 32'd0);
         cyc();
      end
      for (int s = 0; s < 4; s++) load(s, {2'(3 - s), 4'(s), 4'hE});
      wait_pop("mrst_pop_timeout");
      chk("mrst_first_grant0", 32'(src_pop), 32'h1);
      drain();

      // Randomized soak against the FIFO model and scoreboard.
      rcnt = 0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int s;
            s = int'($urandom_range(0, 3));
            if (q[s].size() < 6) begin
               rcnt++;
               if ($urandom_range(0, 7) == 0) load(s, 10'h000);
               else load(s, {2'($urandom), 2'(s), 6'(rcnt)});
            end
         end
         if ($urandom_range(0, 19) == 0)
            dst_almost_full = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
         cyc();
      end
      dst_almost_full = 4'b0000;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
